tx_bram_loader: RTL
===================

Name: tx_bram_loader

Overview:
Writer-side counterpart of the dot11_tx BRAM read interface. It accepts a packet as an 8-bit byte stream with a valid/ready/last handshake, packs the bytes little-endian into 64-bit words, and writes them sequentially into the TX BRAM starting at address 0. Once the packet is fully stored, it launches dot11_tx with phy_tx_start and holds off new input until phy_tx_done.

Parameters:
ADDR_WIDTH, 12, BRAM word-address width; capacity is 2^ADDR_WIDTH 64-bit words.

Ports:
clk  in  1  system clock.
phy_tx_arest  in  1  asynchronous, active-high reset.
s_tdata  in  8  packet byte.
s_tvalid  in  1  byte valid.
s_tready  out  1  byte accepted when s_tvalid&&s_tready.
s_tlast  in  1  marks the final byte of the packet.
bram_addr  out  ADDR_WIDTH  BRAM write word address.
bram_wdata  out  64  BRAM write data.
bram_we  out  1  single-cycle write strobe.
phy_tx_start  out  1  TX launch request to dot11_tx.
phy_tx_started  in  1  dot11_tx acknowledgement of start.
phy_tx_done  in  1  dot11_tx end-of-packet pulse.
word_count  out  ADDR_WIDTH+1  words written for the current packet.
busy  out  1  high in every state except IDLE.
overflow  out  1  one-cycle pulse when a packet exceeds capacity.
tx_done  out  1  one-cycle pulse, registered copy of phy_tx_done seen in WAIT_DONE.

Behaviour:
- Reset values (asynchronous): all outputs 0, state IDLE, byte lane 0, pack register 0.
- States: IDLE, LOAD, START, WAIT_DONE, DRAIN.
- s_tready = 1 in IDLE, LOAD and DRAIN; 0 in START and WAIT_DONE.
- IDLE: the first accepted byte clears word_count and the address and selects lane 0, then moves to LOAD. That byte is packed as in LOAD.
- Packing: byte k of the packet goes to bits [8*(k mod 8)+7 : 8*(k mod 8)].
- Write trigger: a write occurs when lane 7 is filled, or when the accepted byte has s_tlast=1.
- Partial words are zero-padded in the unused upper lanes.
- Write timing: bram_we pulses for 1 cycle, registered, in the cycle after the triggering byte is accepted. bram_addr and bram_wdata are valid in that same cycle.
- After each write, the address increments and word_count increments. bram_addr holds its last value while bram_we=0.
- Full throughput: one byte per cycle; no bubbles are inserted on word boundaries.
- End of packet: the write triggered by an s_tlast byte moves the state to START in the following cycle.
- Packet-start fields: the first data word is written at address 0. The PLCP/SIGNAL header words are supplied by the upstream source as part of the byte stream; this block does not interpret content.
- START: phy_tx_start is held at 1 until phy_tx_started is sampled high. phy_tx_start deasserts in the next cycle, and the state moves to WAIT_DONE.
- WAIT_DONE: on phy_tx_done, tx_done pulses the next cycle and the state returns to IDLE.
- A phy_tx_done that arrives in any other state is ignored.
- Overflow: if the word just written was at address 2^ADDR_WIDTH-1 and its trigger byte was not s_tlast:
  - overflow pulses for 1 cycle;
  - the state moves to DRAIN, which accepts and discards bytes through the s_tlast byte, with no writes;
  - the state then returns to IDLE with no phy_tx_start.
  - word_count saturates at 2^ADDR_WIDTH.
- s_tlast exactly at the last address: this is a normal packet, not an overflow.
- Reset mid-operation: everything returns to reset values immediately, including deasserting phy_tx_start and bram_we. The partial word is lost, and the next packet restarts at address 0.
- s_tvalid low mid-packet: the pack state is held indefinitely. No timeout.

Test Plan:
- 16 bytes 0x00..0x0F, last on 0x0F -> write addr0=0x0706050403020100, addr1=0x0F0E0D0C0B0A0908; word_count=2; phy_tx_start asserted; held until phy_tx_started; tx_done 1 cycle after phy_tx_done.
- 3 bytes 0xAA,0xBB,0xCC, last on 0xCC -> single write addr0=0x0000000000CCBBAA; word_count=1.
- Backpressure: bytes offered continuously through WAIT_DONE -> s_tready=0 from START until tx_done. The next packet writes again from addr0 with word_count restarting at 1.
- ADDR_WIDTH=2, 40-byte packet -> 4 writes (addr 0..3), overflow pulse after addr3 write, remaining 8 bytes drained with no writes, no phy_tx_start, busy=0 after the last byte.
- ADDR_WIDTH=2, exactly 32 bytes -> 4 writes, no overflow, START entered.
- Reset asserted after byte 5 of a packet -> no writes, all outputs 0 asynchronously. A fresh 8-byte packet then writes addr0 correctly.

Source files
------------

// File: rtl/tx_bram_loader.sv
// Byte-stream to 64-bit TX BRAM loader. Packs bytes little-endian, stores the packet
// from word 0, then launches dot11_tx and waits for it to finish before accepting more.
//
// state     | meaning
// IDLE      | waiting for the first byte of a packet
// LOAD      | packing bytes and writing full words
// START     | packet stored, phy_tx_start held until phy_tx_started
// WAIT_DONE | transmitter running, input held off until phy_tx_done
// DRAIN     | packet exceeded capacity, discard bytes through s_tlast
module tx_bram_loader #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  phy_tx_arest,
  input  logic [7:0]            s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic                  s_tlast,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [63:0]           bram_wdata,
  output logic                  bram_we,
  output logic                  phy_tx_start,
  input  logic                  phy_tx_started,
  input  logic                  phy_tx_done,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic                  busy,
  output logic                  overflow,
  output logic                  tx_done
);

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_DONE, DRAIN} state_t;

  localparam logic [ADDR_WIDTH:0] LAST_SLOT = {1'b0, {ADDR_WIDTH{1'b1}}};
  localparam logic [ADDR_WIDTH:0] WC_ONE    = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t              state, state_next;
  logic [2:0]          lane, lane_eff;
  logic [63:0]         pack, pack_eff, word_c;
  logic [ADDR_WIDTH:0] wc_base;
  logic                accept, packing, trigger, full_hit;

  // The first byte of a packet restarts lane, pack and count regardless of leftovers.
  always_comb begin
    accept   = s_tvalid && s_tready;
    packing  = (state == IDLE) || (state == LOAD);
    lane_eff = (state == IDLE) ? 3'd0 : lane;
    pack_eff = (state == IDLE) ? 64'd0 : pack;
    wc_base  = (state == IDLE) ? '0 : word_count;
    word_c   = pack_eff | (64'(s_tdata) << {lane_eff, 3'b000});
    trigger  = accept && packing && ((lane_eff == 3'd7) || s_tlast);
    full_hit = trigger && !s_tlast && (wc_base == LAST_SLOT);
  end

  always_comb begin
    state_next   = state;
    busy         = (state != IDLE);
    phy_tx_start = (state == START);
    case (state)
      IDLE, LOAD: begin
        if (trigger) begin
          if (full_hit)     state_next = DRAIN;
          else if (s_tlast) state_next = START;
          else              state_next = LOAD;
        end else if (accept) begin
          state_next = LOAD;
        end
      end
      START:     if (phy_tx_started) state_next = WAIT_DONE;
      WAIT_DONE: if (phy_tx_done)    state_next = IDLE;
      DRAIN:     if (accept && s_tlast) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge phy_tx_arest) begin
    if (phy_tx_arest) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Ready is registered from the next state so it reads 0 while in reset.
  always_ff @(posedge clk or posedge phy_tx_arest) begin
    if (phy_tx_arest) begin
      s_tready   <= 1'b0;
      bram_we    <= 1'b0;
      bram_addr  <= '0;
      bram_wdata <= '0;
      word_count <= '0;
      overflow   <= 1'b0;
      tx_done    <= 1'b0;
      lane       <= 3'd0;
      pack       <= '0;
    end else begin
      s_tready <= (state_next == IDLE) || (state_next == LOAD) || (state_next == DRAIN);
      bram_we  <= trigger;
      overflow <= full_hit;
      tx_done  <= (state == WAIT_DONE) && phy_tx_done;
      if (accept && packing) begin
        if (trigger) begin
          bram_wdata <= word_c;
          bram_addr  <= wc_base[ADDR_WIDTH-1:0];
          word_count <= wc_base + WC_ONE;
          pack       <= '0;
          lane       <= 3'd0;
        end else begin
          pack <= word_c;
          lane <= lane_eff + 3'd1;
          if (state == IDLE) begin
            word_count <= '0;
            bram_addr  <= '0;
          end
        end
      end
    end
  end

endmodule
